// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data (older instruction) wins ties; each transaction is held until ack or timeout.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_ready,
  output logic                  m_req,
  output logic                  m_we,
  output logic [DATA_W/8-1:0]   m_be,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_ack,
  output logic                  stall_if,
  output logic                  stall_mem,
  output logic                  err
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       d_elig;
  logic       i_elig;

  // A requester whose ready pulse is high this cycle has already been served.
  assign d_elig    = d_req & ~d_ready;
  assign i_elig    = if_req & ~if_ready;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_be     <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (d_elig) begin
            state_q <= StBusyD;
            cnt_q   <= 8'd0;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_be    <= d_be;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
          end else if (i_elig) begin
            state_q <= StBusyI;
            cnt_q   <= 8'd0;
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_be    <= '1;
            m_addr  <= if_addr;
          end
        end
        StBusyI, StBusyD: begin
          if (m_ack) begin
            state_q <= StIdle;
            m_req   <= 1'b0;
            if (state_q == StBusyI) begin
              if_ready <= 1'b1;
              if_rdata <= m_rdata;
            end else begin
              d_ready <= 1'b1;
              if (!m_we) d_rdata <= m_rdata;
            end
          end else if (cnt_q == CntLast) begin
            // Abort: release the port and return zero data with a sticky error.
            state_q <= StIdle;
            m_req   <= 1'b0;
            err     <= 1'b1;
            if (state_q == StBusyI) begin
              if_ready <= 1'b1;
              if_rdata <= '0;
            end else begin
              d_ready <= 1'b1;
              d_rdata <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares one single-ported memory between the pipeline's instruction-fetch (IF) and data-access (MEM) stages. It serialises requests, gives the older instruction (MEM) priority, holds each transaction on the memory port until acknowledge or timeout, and returns registered read data with a one-cycle ready pulse. Combinational stall outputs feed the pipeline stall logic so IF and MEM freeze while their access is pending.

## Interface

Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte enables are `DATA_W/8` bits.
- `TIMEOUT`, default 15: maximum cycles a transaction waits for `m_ack`; legal range 1..255.

Ports:
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `if_req`, input, 1: fetch request; held high until `if_ready`.
- `if_addr`, input, ADDR_W: fetch address; stable while `if_req` is high.
- `if_rdata`, output, DATA_W: registered fetch data.
- `if_ready`, output, 1: one-cycle completion pulse for fetch.
- `d_req`, input, 1: data request; held high until `d_ready`.
- `d_we`, input, 1: 1 = store, 0 = load.
- `d_be`, input, DATA_W/8: byte enables for a store.
- `d_addr`, input, ADDR_W: data address.
- `d_wdata`, input, DATA_W: store data.
- `d_rdata`, output, DATA_W: registered load data.
- `d_ready`, output, 1: one-cycle completion pulse for data.
- `m_req`, output, 1: memory request; held high until acknowledge or abort.
- `m_we`, `m_be`, `m_addr`, `m_wdata`, output: registered copies of the granted request.
- `m_rdata`, input, DATA_W: memory read data; valid in the `m_ack` cycle.
- `m_ack`, input, 1: memory completion, one cycle.
- `stall_if`, output, 1: `if_req & ~if_ready`.
- `stall_mem`, output, 1: `d_req & ~d_ready`.
- `err`, output, 1: sticky timeout flag; cleared only by reset.

## Operation

- FSM states: IDLE, BUSY_I, BUSY_D.
- **Grant from IDLE:**
  - If `d_req` is high, go to BUSY_D; otherwise, if `if_req` is high, go to BUSY_I.
  - MEM has fixed priority over IF.
  - On a grant edge, `m_*` are loaded from the granted requester and `m_req` is set to 1.
- **Served-requester mask:** in the cycle a requester's ready is high, its request is ignored by IDLE arbitration. The other requester may be granted in that same cycle.
- **Fetch transactions:** `m_we` = 0 and `m_be` = all ones.
- **Completion:** `m_ack` sampled high in BUSY_x leads, at the next edge, to:
  - state goes to IDLE and `m_req` goes to 0;
  - `x_ready` goes to 1 for exactly one cycle;
  - on a load or fetch, `x_rdata` is loaded with `m_rdata`;
  - on a store, `d_rdata` is unchanged.
- **Timeout:**
  - An 8-bit wait counter clears on grant and increments in every BUSY cycle without `m_ack`.
  - If the counter equals TIMEOUT-1 and `m_ack` is low, the next edge aborts the transaction.
  - Abort effects: `m_req` goes to 0, state goes to IDLE, `x_ready` pulses, `x_rdata` is set to 0, and `err` is set to 1.
  - If `m_ack` arrives in the same cycle as the timeout condition, the acknowledge wins and no error is raised.
- **Spurious acknowledge:** `m_ack` while in IDLE is ignored; no outputs change.
- **Stall outputs:** both are combinational, so the pipeline stalls in the request cycle itself.
- **Reset:**
  - `rst_n` low at an edge forces IDLE, `m_req`/`m_we` = 0, `m_be`/`m_addr`/`m_wdata` = 0, `if_rdata`/`d_rdata` = 0, both ready outputs = 0, `err` = 0, and the counter = 0.
  - An in-flight transaction is abandoned, and a late `m_ack` after reset is ignored.

## Timing

- Minimum latency, zero-wait memory:
  - cycle 0: `x_req` high;
  - cycle 1: `m_req` high and memory returns `m_ack`;
  - cycle 2: `x_ready` high.
- With N wait cycles before `m_ack`, `x_ready` is at cycle 2+N.
- Back-to-back requests: the first is served at cycle 2, and the second can be granted at the cycle-2 edge, so `m_req` is high again at cycle 3.
- Abort timing: `x_ready` occurs at cycle 1+TIMEOUT.
- `m_req` is never high for more than TIMEOUT consecutive cycles per transaction.
- `m_req` is low for at least one cycle between transactions.
- Throughput is at most one transaction per 2 cycles.
- All outputs except `stall_if` and `stall_mem` are registered.

## Test plan

- **Single load, zero-wait:**
  - Stimulus: `d_req`=1, `d_we`=0, `d_addr`=0x100; memory acks in the first `m_req` cycle with 0xCAFEF00D.
  - Response: `m_addr`=0x100 at cycle 1; `d_ready`=1 at cycle 2 with `d_rdata`=0xCAFEF00D; `stall_mem`=1 in cycles 0–1.
- **Simultaneous requests:**
  - Stimulus: `if_req` and `d_req` raised together with 2-wait memory.
  - Response: data is granted first with `d_ready` at cycle 4; fetch `m_req` goes high at cycle 5 and `if_ready` arrives at cycle 8.
- **Store:**
  - Stimulus: `d_we`=1, `d_be`=4'b0011, `d_wdata`=0x12345678.
  - Response: `m_we`=1, `m_be`=0011, and `m_wdata` match; after `d_ready`, `d_rdata` keeps its prior value.
- **Timeout:**
  - Stimulus: TIMEOUT=4 and memory never acks.
  - Response: `m_req` is high in cycles 1–4; `d_ready` pulses at cycle 5 with `d_rdata`=0; `err`=1 and remains 1.
- **Ack/timeout race:**
  - Stimulus: `m_ack` arrives in exactly the TIMEOUT-th BUSY cycle.
  - Response: normal completion with captured data and `err`=0.
- **Reset mid-transaction:**
  - Stimulus: `rst_n`=0 in cycle 2 of a 5-wait fetch, then `m_ack` is pulsed after reset.
  - Response: outputs are zero after the reset edge; no `if_ready` pulse and no state change on the late ack.
